alu_bist_checker: RTL
=====================

# alu_bist_checker

Self-checking built-in test controller for the 4-bit ALU. It drives every combination of `A`, `B` and `{s1,s0}` into the ALU's input pins (1024 vectors) and samples the 5-bit `Out` after a settle interval. Each sample is compared against an internal reference model, and the block reports a pass/fail verdict, a saturating error count and the first failing vector. It sits beside the ALU in the top level and replaces the hand-written stimulus bench for silicon and gate-level bring-up.

## Interface
- `SETTLE`, default 1: cycles each vector is held before sampling; legal range ≥ 1.
- `ERR_W`, default 8: width of `err_count`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; sampled in IDLE or DONE only.
- `alu_out` in 5: ALU `Out`.
- `alu_a` out 4: drives ALU `A`.
- `alu_b` out 4: drives ALU `B`.
- `alu_s0` out 1: drives ALU `s0`.
- `alu_s1` out 1: drives ALU `s1`.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until the next start or reset.
- `pass` out 1: `done` is high and `err_count` is 0.
- `err_count` out `ERR_W`: mismatch count; saturates at 2^ERR_W−1.
- `fail_valid` out 1: at least one mismatch has been captured this run.
- `fail_vec` out 10: `{s1,s0,A,B}` of the first mismatch.
- `fail_got` out 5: `alu_out` value sampled at the first mismatch.

## Operation
- **Vector index:** 10-bit counter `idx = {s1,s0,A,B}` running from 0 to 1023. `B` is the fastest-changing field. The ALU outputs are driven directly from `idx` and are registered.
- **Reference model (5-bit result):**
  - 00: `{1'b0,A} + {1'b0,B}`.
  - 01: `({1'b0,A} − {1'b0,B}) mod 32`; bit 4 is the borrow.
  - 10: `{2'b00, A>B, A==B, A<B}`, unsigned compare.
  - 11: `{1'b0, A&B}`.
- **FSM states:** IDLE, DRIVE, CHECK, DONE.
- **IDLE:**
  - `start`=1 moves to DRIVE.
  - On entry to DRIVE: `idx`=0, settle counter=`SETTLE`, and `err_count`, `fail_*`, `done` and `pass` are cleared.
- **DRIVE:**
  - Holds the current vector and decrements the settle counter.
  - Moves to CHECK after exactly `SETTLE` cycles.
- **CHECK (one cycle):**
  - Compares `alu_out` with the model for the current `idx`.
  - On mismatch, `err_count` increments (saturating). If `fail_valid` is 0, the block also captures `fail_vec`=`idx` and `fail_got`=`alu_out` and sets `fail_valid`.
  - If `idx`=1023, moves to DONE. Otherwise `idx` increments, the settle counter reloads, and the FSM returns to DRIVE.
- **DONE:**
  - `done`=1 and `busy`=0; the ALU outputs hold the last vector.
  - `start`=1 restarts exactly as from IDLE, including clearing all results.
- **Boundary conditions:**
  - `start` while `busy` is ignored.
  - A mismatch arriving after `err_count` has saturated leaves it at its maximum.
  - `fail_*` registers never update after the first capture within a run.

## Timing
- **Reset:** asserting `rst` at any time, including mid-run, immediately forces IDLE. All outputs go to 0: `alu_a`, `alu_b`, `alu_s0`, `alu_s1`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `fail_vec`, `fail_got`.
- **Run start:** with `start` sampled high at edge k, `busy`=1 and vector 0 appear on the ALU outputs after edge k.
- **Per-vector cost:** `SETTLE`+1 cycles.
- **Run length:** `done` rises after edge k + 1024·(`SETTLE`+1). With the default, this is k+2048.
- **End of run:** `busy` falls in the same cycle that `done` rises. `pass` and the final `err_count` are valid in that same cycle.
- **Sampling:** `alu_out` is sampled on the edge that leaves CHECK. The ALU's combinational path must settle within `SETTLE` cycles plus one.

## Test plan
- **Golden run:** golden combinational ALU model, `SETTLE`=1, pulse `start` → `done` at start+2048, `err_count`=0, `pass`=1, `fail_valid`=0. Spot-check the vectors driven:
  - `{01,A=10,B=3}` expects 5'b00111.
  - `{01,A=3,B=10}` expects 5'b11001.
  - `{10,A=4,B=3}` expects 5'b00100.
  - `{11,A=12,B=10}` expects 5'b01000.
- **Single fault:** ALU bit 4 inverted only for `{00,F,F}` → `err_count`=1, `fail_vec`=10'h0FF, `fail_got`=5'b01110, `pass`=0.
- **Saturation:** `alu_out` tied to 0, `ERR_W`=4 → `err_count`=15, `fail_vec`=10'h001, `fail_got`=0.
- **Reset mid-run:** assert `rst` 500 cycles after start → all outputs 0 immediately. A fresh `start` completes in 2048 cycles with `pass`=1.
- **Start handling:** a `start` pulse 100 cycles into a run has no effect; `done` still arrives at 2048. A `start` in DONE clears the results and reruns.
- **Settle parameter:** `SETTLE`=3 → `done` at start+4096; each vector is held for 4 cycles.

Source files
------------

// File: rtl/alu_bist_checker_if.sv
// Pin bundle between the BIST checker and the 4-bit ALU under test.
// The checker is master: it drives A/B/s1/s0 and receives Out.
interface alu_bist_checker_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_s0;
  logic       alu_s1;
  logic [4:0] alu_out;

  modport master (output alu_a, output alu_b, output alu_s0, output alu_s1,
                  input  alu_out);
  modport slave  (input  alu_a, input  alu_b, input  alu_s0, input  alu_s1,
                  output alu_out);
endinterface

// File: rtl/alu_bist_checker.sv
// Exhaustive self-checking test controller for the 4-bit ALU: sweeps all
// 1024 {s1,s0,A,B} vectors, compares Out with a reference model, logs faults.
module alu_bist_checker #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  alu_bist_checker_if.master   alu,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic                 fail_valid,
  output logic [9:0]           fail_vec,
  output logic [4:0]           fail_got
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t           r_state;
  logic [9:0]       r_idx;
  logic [CNT_W-1:0] r_settle;
  logic [ERR_W-1:0] r_err;
  logic             r_fail_valid;
  logic [9:0]       r_fail_vec;
  logic [4:0]       r_fail_got;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;

  function automatic logic [4:0] ref_model(input logic [9:0] v);
    logic [3:0] a;
    logic [3:0] b;
    a = v[7:4];
    b = v[3:0];
    case (v[9:8])
      2'b00:   ref_model = {1'b0, a} + {1'b0, b};
      2'b01:   ref_model = {1'b0, a} - {1'b0, b};
      2'b10:   ref_model = {2'b00, a > b, a == b, a < b};
      default: ref_model = {1'b0, a & b};
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  assign w_mismatch = (alu.alu_out != ref_model(r_idx));
  assign w_err_next = w_mismatch ? sat_inc(r_err) : r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_settle     <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
      r_fail_got   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_DRIVE;
            r_idx        <= '0;
            r_settle     <= SETTLE_LD;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_fail_got   <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_settle <= r_settle - 1'b1;
          if (r_settle == CNT_W'(1)) r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_err <= w_err_next;
          // Only the first failing vector of a run is kept for debug.
          if (w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_vec   <= r_idx;
            r_fail_got   <= alu.alu_out;
          end
          if (r_idx == 10'd1023) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_state  <= S_DRIVE;
            r_idx    <= r_idx + 1'b1;
            r_settle <= SETTLE_LD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu.alu_s1 = r_idx[9];
  assign alu.alu_s0 = r_idx[8];
  assign alu.alu_a  = r_idx[7:4];
  assign alu.alu_b  = r_idx[3:0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;
  assign fail_got   = r_fail_got;

endmodule
